// File: rtl/nx_instr_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds instr_t, fetch_state_t and the fetch credit limit.
package nx_instr_pkg;

  localparam int INSTR_W       = 15;
  localparam int FETCH_CREDITS = 2;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/nx_instr_fetch_fifo.sv
// Two-entry synchronous FIFO carrying {last, data} to the core.
// Ports: clk, rst, push/wdata/wlast, pop/rdata/rlast, full, empty.
module nx_instr_fetch_fifo #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         wlast,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         rlast,
  output logic         full,
  output logic         empty
);

  logic [W:0] mem [2];
  logic       wp;
  logic       rp;
  logic [1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= {wlast, wdata};
        wp      <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
      end
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  assign {rlast, rdata} = mem[rp];
  assign full           = (cnt == 2'd2);
  assign empty          = (cnt == 2'd0);

endmodule

// File: rtl/nx_instr_fetch.sv
// Streams instructions 0..populated-1 from the store to the core on trigger.
// Ports: clk_i, rst_i, populated_i, trigger_i, store_addr_o, store_rd_o,
//   store_data_i, store_stall_i, instr_data_o, instr_valid_o,
//   instr_last_o, instr_ready_i, busy_o, done_o.
// Option NX_INSTR_FETCH_OVERRUN_EN adds sticky output trigger_overrun_o.
module nx_instr_fetch #(
  parameter  int INSTR_WIDTH = 15,
  parameter  int MAX_INSTRS  = 512,
  localparam int ADDR_W      = $clog2(MAX_INSTRS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [ADDR_W-1:0]      populated_i,
  input  logic                   trigger_i,
  output logic [ADDR_W-1:0]      store_addr_o,
  output logic                   store_rd_o,
  input  logic [INSTR_WIDTH-1:0] store_data_i,
  input  logic                   store_stall_i,
  output logic [INSTR_WIDTH-1:0] instr_data_o,
  output logic                   instr_valid_o,
  output logic                   instr_last_o,
  input  logic                   instr_ready_i,
  output logic                   busy_o,
  output logic                   done_o
`ifdef NX_INSTR_FETCH_OVERRUN_EN
  ,
  output logic                   trigger_overrun_o
`endif
);

  import nx_instr_pkg::*;

  fetch_state_t      state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] end_q;
  logic [1:0]        used_q;
  logic              pend_q;
  logic              pend_last_q;
  logic              done_q;

  logic              start;
  logic              credit_ok;
  logic              issue;
  logic              accept;
  logic              pop;
  logic              push;
  logic              last_addr;
  logic              head_last;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] cur_end;

  // The first read goes out in the trigger cycle itself so that data
  // reaches the core two cycles after the trigger.
  assign start    = (state == IDLE) & trigger_i & ~done_q;
  assign cur_addr = (state == IDLE) ? '0 : addr_q;
  assign cur_end  = (state == IDLE) ? populated_i : end_q;

  assign pop  = instr_valid_o & instr_ready_i;
  assign push = pend_q & (~full | pop);

  // used_q counts buffered plus in-flight words; a same-cycle pop frees one.
  assign credit_ok = (used_q < 2'(FETCH_CREDITS)) | pop;
  assign issue     = credit_ok
                   & ((start & (|populated_i)) | (state == FETCH));
  assign accept    = issue & ~store_stall_i;
  assign last_addr = (cur_addr == cur_end - ADDR_W'(1));

  assign store_addr_o  = cur_addr;
  assign store_rd_o    = issue;
  assign instr_valid_o = ~empty;
  assign instr_last_o  = head_last & ~empty;
  assign busy_o        = (state != IDLE);
  assign done_o        = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      addr_q      <= '0;
      end_q       <= '0;
      used_q      <= 2'd0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      pend_q      <= accept;
      pend_last_q <= accept & last_addr;
      used_q      <= used_q + 2'(accept) - 2'(pop);
      if (accept) begin
        addr_q <= cur_addr + ADDR_W'(1);
      end else if (start) begin
        addr_q <= '0;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            end_q <= populated_i;
            if (populated_i == '0) begin
              done_q <= 1'b1;
            end else if (accept & last_addr) begin
              state <= DRAIN;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          if (accept & last_addr) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop & instr_last_o) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  nx_instr_fetch_fifo #(
    .W(INSTR_WIDTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (store_data_i),
    .wlast (pend_last_q),
    .pop   (pop),
    .rdata (instr_data_o),
    .rlast (head_last),
    .full  (full),
    .empty (empty)
  );

`ifdef NX_INSTR_FETCH_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overrun_q <= 1'b0;
    end else if (trigger_i & busy_o) begin
      overrun_q <= 1'b1;
    end
  end

  assign trigger_overrun_o = overrun_q;
`endif

endmodule

// File: tb/tb_nx_instr_fetch.sv
// Directed self-checking bench for nx_instr_fetch.
// Models the store with one-cycle read latency and logs accepted words.
module tb_nx_instr_fetch;

  localparam int IW = 15;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [AW-1:0] populated_i;
  logic          trigger_i;
  logic [AW-1:0] store_addr_o;
  logic          store_rd_o;
  logic [IW-1:0] store_data_i;
  logic          store_stall_i;
  logic [IW-1:0] instr_data_o;
  logic          instr_valid_o;
  logic          instr_last_o;
  logic          instr_ready_i;
  logic          busy_o;
  logic          done_o;
`ifdef NX_INSTR_FETCH_OVERRUN_EN
  logic          trigger_overrun_o;
`endif

  nx_instr_fetch dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .populated_i   (populated_i),
    .trigger_i     (trigger_i),
    .store_addr_o  (store_addr_o),
    .store_rd_o    (store_rd_o),
    .store_data_i  (store_data_i),
    .store_stall_i (store_stall_i),
    .instr_data_o  (instr_data_o),
    .instr_valid_o (instr_valid_o),
    .instr_last_o  (instr_last_o),
    .instr_ready_i (instr_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
`ifdef NX_INSTR_FETCH_OVERRUN_EN
    ,
    .trigger_overrun_o (trigger_overrun_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [IW-1:0] f(input logic [AW-1:0] a);
    return {6'h2b, a} ^ 15'h0155;
  endfunction

  // store model: one-cycle read latency, junk when nothing was read
  logic          req_v = 1'b0;
  logic [AW-1:0] req_a = '0;
  always @(posedge clk) store_data_i <= req_v ? f(req_a) : '1;

  // monitor, sampled mid-cycle
  logic [IW-1:0] q_data [$];
  logic          q_last [$];
  int            q_cyc  [$];
  int            done_cnt, done_cyc, acc_cnt, pop_cnt, max_infl;
  bit            busy_seen, rd_seen;

  always @(negedge clk) begin
    req_v = store_rd_o && !store_stall_i;
    req_a = store_addr_o;
    if (instr_valid_o && instr_ready_i) begin
      q_data.push_back(instr_data_o);
      q_last.push_back(instr_last_o);
      q_cyc.push_back(cyc);
      pop_cnt++;
    end
    if (req_v) acc_cnt++;
    if (acc_cnt - pop_cnt > max_infl) max_infl = acc_cnt - pop_cnt;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy_o) busy_seen = 1'b1;
    if (store_rd_o) rd_seen = 1'b1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    acc_cnt   = 0;
    pop_cnt   = 0;
    max_infl  = 0;
    busy_seen = 1'b0;
    rd_seen   = 1'b0;
  endtask

  int tc;

  task automatic trig(input int p);
    populated_i = AW'(p);
    trigger_i   = 1'b1;
    tc          = cyc;
    tick();
    trigger_i   = 1'b0;
  endtask

  task automatic check_words(input string tag, input int n);
    check({tag, "_count"}, q_data.size(), n);
    for (int i = 0; i < n && i < q_data.size(); i++) begin
      check($sformatf("%s_d%0d", tag, i), q_data[i], f(AW'(i)));
      check($sformatf("%s_l%0d", tag, i), q_last[i], (i == n - 1));
    end
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_valid"}, instr_valid_o, 0);
    check({tag, "_last"}, instr_last_o, 0);
    check({tag, "_rd"}, store_rd_o, 0);
    check({tag, "_addr"}, store_addr_o, 0);
  endtask

  bit found;

  initial begin
    rst_i         = 1'b1;
    populated_i   = '0;
    trigger_i     = 1'b0;
    store_stall_i = 1'b0;
    instr_ready_i = 1'b1;
    clear_mon();
    tick(3);
    check_idle_outs("rst");
    check("rst_data", instr_data_o, 0);
    rst_i = 1'b0;
    tick();

    // basic pass of 4 words at full rate
    clear_mon();
    trig(4);
    check("p4_busy", busy_o, 1);
    tick(12);
    check_words("p4", 4);
    if (q_cyc.size() == 4) begin
      check("p4_first_cyc", q_cyc[0], tc + 2);
      check("p4_last_cyc", q_cyc[3], tc + 5);
    end
    check("p4_done_cyc", done_cyc, tc + 6);
    check("p4_done_cnt", done_cnt, 1);
    check("p4_busy_end", busy_o, 0);

    // empty pass; trigger held into the done cycle must be ignored
    clear_mon();
    populated_i = '0;
    trigger_i   = 1'b1;
    tc          = cyc;
    tick();
    check("p0_done", done_o, 1);
    check("p0_busy", busy_o, 0);
    tick();
    trigger_i = 1'b0;
    check("p0_done_gone", done_o, 0);
    tick(5);
    check("p0_done_cnt", done_cnt, 1);
    check("p0_no_rd", rd_seen, 0);
    check("p0_no_busy", busy_seen, 0);

    // store stall on address 2
    clear_mon();
    trig(6);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (store_rd_o && store_addr_o == AW'(2)) found = 1'b1;
      else tick();
    end
    check("st_found", found, 1);
    store_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("st_addr%0d", i), store_addr_o, 2);
      check($sformatf("st_rd%0d", i), store_rd_o, 1);
      tick();
    end
    store_stall_i = 1'b0;
    tick(15);
    check_words("st", 6);
    check("st_done_cnt", done_cnt, 1);

    // core back-pressure
    instr_ready_i = 1'b0;
    clear_mon();
    trig(5);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (instr_valid_o) found = 1'b1;
      else tick();
    end
    check("bp_found", found, 1);
    tick(4);
    check("bp_held_valid", instr_valid_o, 1);
    instr_ready_i = 1'b1;
    tick(15);
    check_words("bp", 5);
    check("bp_max_infl", max_infl, 2);
    check("bp_done_cnt", done_cnt, 1);

    // second trigger while busy is dropped
    clear_mon();
    trig(3);
    tick();
`ifdef NX_INSTR_FETCH_OVERRUN_EN
    check("ov_flag_pre", trigger_overrun_o, 0);
`endif
    populated_i = AW'(7);
    trigger_i   = 1'b1;
    tick();
    trigger_i   = 1'b0;
`ifdef NX_INSTR_FETCH_OVERRUN_EN
    check("ov_flag_set", trigger_overrun_o, 1);
`endif
    tick(12);
    check_words("ov", 3);
    check("ov_done_cnt", done_cnt, 1);
`ifdef NX_INSTR_FETCH_OVERRUN_EN
    check("ov_flag_sticky", trigger_overrun_o, 1);
`endif

    // reset in the middle of an 8-word pass
    clear_mon();
    trig(8);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (store_rd_o && !store_stall_i && store_addr_o == AW'(3))
        found = 1'b1;
      else tick();
    end
    check("mr_found", found, 1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_idle_outs("mr");
`ifdef NX_INSTR_FETCH_OVERRUN_EN
    check("mr_ov_clr", trigger_overrun_o, 0);
`endif
    clear_mon();
    tick(6);
    check("mr_no_words", q_data.size(), 0);
    check("mr_no_done", done_cnt, 0);
    check("mr_no_busy", busy_seen, 0);

    clear_mon();
    trig(3);
    tick(12);
    check_words("rs", 3);
    if (q_cyc.size() > 0) check("rs_first_cyc", q_cyc[0], tc + 2);
    check("rs_done_cnt", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
